// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared definitions for the register-bank write block: default sizes,
// the fixed number of register output ports, and the write FSM states.
package reg_bank_pkg;

  localparam int N_REGS_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // The block always exposes D0..D7; registers beyond N_REGS read as zero.
  localparam int N_OUT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank_write.sv
// reg_bank_write
// Write side of a small register bank. Plain writes land directly in IDLE.
// A clear request zeroes one register per cycle. Any write that arrives during
// a clear, or together with the clear request, is held in a one-entry pending
// buffer and committed after the clear so it is not wiped out.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   we        write request
//   wa        write address (ADDR_W bits)
//   wd        write data (DATA_W bits)
//   clr_req   request to zero every register
//   wr_ready  high when a write can be accepted (pending buffer empty)
//   busy      registered, high during CLEAR and DRAIN
//   addr_err  one-cycle pulse after an out-of-range write is accepted
//   D0..D7    register contents for the read mux
module reg_bank_write
  import reg_bank_pkg::*;
#(
  parameter int N_REGS  = N_REGS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              clr_req,
  output logic              wr_ready,
  output logic              busy,
  output logic              addr_err,
  output logic [DATA_W-1:0] D0,
  output logic [DATA_W-1:0] D1,
  output logic [DATA_W-1:0] D2,
  output logic [DATA_W-1:0] D3,
  output logic [DATA_W-1:0] D4,
  output logic [DATA_W-1:0] D5,
  output logic [DATA_W-1:0] D6,
  output logic [DATA_W-1:0] D7
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] regs [N_OUT];

  logic accept;
  logic in_range;

  assign wr_ready = ~pend_valid;
  assign accept   = we & ~pend_valid;
  assign in_range = int'(wa) < N_REGS;

  // Writes are decoded with a constant loop, not a variable index, so that
  // address bits wider than the register count never select past the array.
  // Register 0 is simply never written when it is hardwired to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      busy       <= 1'b0;
      addr_err   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) regs[i] <= '0;
    end else begin
      addr_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
            // A write in the same cycle as the clear must follow the clear.
            if (accept) begin
              if (in_range) begin
                pend_valid <= 1'b1;
                pend_addr  <= wa;
                pend_data  <= wd;
              end else begin
                addr_err <= 1'b1;
              end
            end
          end else if (accept) begin
            if (in_range) begin
              for (int i = 0; i < N_OUT; i++) begin
                if (i < N_REGS && wa == ADDR_W'(i) && !(R0_ZERO && i == 0))
                  regs[i] <= wd;
              end
            end else begin
              addr_err <= 1'b1;
            end
          end
        end

        CLEAR: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (cnt == ADDR_W'(i)) regs[i] <= '0;
          end
          cnt <= cnt + ADDR_W'(1);
          if (accept) begin
            if (in_range) begin
              pend_valid <= 1'b1;
              pend_addr  <= wa;
              pend_data  <= wd;
            end else begin
              addr_err <= 1'b1;
            end
          end
          // A write captured on the last clear cycle still needs a drain.
          if (cnt == ADDR_W'(N_REGS - 1)) begin
            if (pend_valid || (accept && in_range)) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DRAIN: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (i < N_REGS && pend_addr == ADDR_W'(i) && !(R0_ZERO && i == 0))
              regs[i] <= pend_data;
          end
          pend_valid <= 1'b0;
          state      <= IDLE;
          busy       <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign D0 = R0_ZERO ? '0 : regs[0];
  assign D1 = regs[1];
  assign D2 = regs[2];
  assign D3 = regs[3];
  assign D4 = regs[4];
  assign D5 = regs[5];
  assign D6 = regs[6];
  assign D7 = regs[7];

endmodule

// File: tb/tb_reg_bank_write.sv
// tb_reg_bank_write
// Self-checking bench for reg_bank_write with default parameters. A reference
// model tracks register contents, the pending write queue and the remaining
// busy cycles, and every output is compared after each clock edge.
module tb_reg_bank_write;
  import reg_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [3:0] wa;
  logic [7:0] wd;
  logic       clr_req;
  logic       wr_ready;
  logic       busy;
  logic       addr_err;
  logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic [7:0] dv [8];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } pend_t;

  logic [7:0] mem [8];
  pend_t      pendq [$];
  int         busy_left;
  int         clr_pos;
  bit         err_exp;

  reg_bank_write dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .clr_req(clr_req),
    .wr_ready(wr_ready), .busy(busy), .addr_err(addr_err),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7)
  );

  always #5 clk = ~clk;

  assign dv[0] = D0;
  assign dv[1] = D1;
  assign dv[2] = D2;
  assign dv[3] = D3;
  assign dv[4] = D4;
  assign dv[5] = D5;
  assign dv[6] = D6;
  assign dv[7] = D7;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A write taken while a clear is pending joins the queue and lengthens the
  // busy period by one drain cycle; an out-of-range one only flags an error.
  task automatic modelCapture();
    if (wa >= 4'd8) begin
      err_exp = 1'b1;
    end else begin
      pendq.push_back('{a: wa, d: wd});
      busy_left++;
    end
  endtask

  task automatic modelStep();
    bit    acc;
    pend_t p;
    if (rst) begin
      foreach (mem[i]) mem[i] = 8'h00;
      pendq.delete();
      busy_left = 0;
      clr_pos   = 8;
      err_exp   = 1'b0;
      return;
    end
    err_exp = 1'b0;
    acc     = we && (pendq.size() == 0);
    if (busy_left == 0) begin
      if (clr_req) begin
        busy_left = 8;
        clr_pos   = 0;
        if (acc) modelCapture();
      end else if (acc) begin
        if (wa >= 4'd8) err_exp = 1'b1;
        else if (wa != 4'd0) mem[wa[2:0]] = wd;
      end
    end else begin
      if (clr_pos < 8) begin
        mem[clr_pos] = 8'h00;
        clr_pos++;
        if (acc) modelCapture();
      end else begin
        p = pendq.pop_front();
        if (p.a != 4'd0) mem[p.a[2:0]] = p.d;
      end
      busy_left--;
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("D%0d", i), 32'(dv[i]), 32'(mem[i]));
    checkOutput("busy", 32'(busy), 32'(busy_left > 0));
    checkOutput("wr_ready", 32'(wr_ready), 32'(pendq.size() == 0));
    checkOutput("addr_err", 32'(addr_err), 32'(err_exp));
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [3:0] a,
                               input logic [7:0] d, input bit c);
    rst = r; we = w; wa = a; wd = d; clr_req = c;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  // Counts the busy cycles of a clear started by the step just applied.
  task automatic countBusy(output int n);
    n = busy ? 1 : 0;
    for (int k = 0; k < 20 && busy; k++) begin
      applyStimulus(0, 0, 4'd0, 8'h00, 0);
      if (busy) n++;
    end
  endtask

  initial begin
    int n;
    bit r, w, c;

    // Reset
    applyStimulus(1, 0, 4'd0, 8'h00, 0);
    applyStimulus(1, 1, 4'd3, 8'h77, 1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Scenario 1: plain write
    applyStimulus(0, 1, 4'd3, 8'hA5, 0);
    checkOutput("s1_d3", 32'(D3), 32'hA5);
    checkOutput("s1_addr_err", 32'(addr_err), 32'd0);

    // Scenario 2: out-of-range write
    applyStimulus(0, 1, 4'd9, 8'h11, 0);
    checkOutput("s2_addr_err", 32'(addr_err), 32'd1);
    applyStimulus(0, 0, 4'd0, 8'h00, 0);
    checkOutput("s2_addr_err_end", 32'(addr_err), 32'd0);

    // Scenario 3: register 0 is hardwired
    applyStimulus(0, 1, 4'd0, 8'hFF, 0);
    checkOutput("s3_d0", 32'(D0), 32'd0);
    checkOutput("s3_addr_err", 32'(addr_err), 32'd0);

    // Scenario 4: preload then clear
    for (int i = 1; i < 8; i++) applyStimulus(0, 1, 4'(i), 8'h5A, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1);
    countBusy(n);
    checkOutput("s4_busy_cycles", 32'(n), 32'd8);
    for (int i = 1; i < 8; i++)
      checkOutput($sformatf("s4_D%0d_zero", i), 32'(dv[i]), 32'd0);

    // Scenario 5: clear and write together
    for (int i = 1; i < 8; i++) applyStimulus(0, 1, 4'(i), 8'h5A, 0);
    applyStimulus(0, 1, 4'd2, 8'h3C, 1);
    checkOutput("s5_wr_ready_capture", 32'(wr_ready), 32'd0);
    countBusy(n);
    checkOutput("s5_busy_cycles", 32'(n), 32'd9);
    checkOutput("s5_d2", 32'(D2), 32'h3C);
    checkOutput("s5_d5", 32'(D5), 32'd0);

    // Scenario 6: second write blocked, then reset mid-clear
    for (int i = 1; i < 8; i++) applyStimulus(0, 1, 4'(i), 8'h5A, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1);
    applyStimulus(0, 1, 4'd5, 8'h77, 0);
    applyStimulus(0, 1, 4'd6, 8'h88, 0);
    checkOutput("s6_wr_ready_full", 32'(wr_ready), 32'd0);
    applyStimulus(0, 0, 4'd0, 8'h00, 0);
    applyStimulus(1, 0, 4'd0, 8'h00, 0);
    checkOutput("s6_state", 32'(dut.state), 32'(IDLE));
    checkOutput("s6_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("s6_d6", 32'(D6), 32'd0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 4'd0, 8'h00, 0);
    checkOutput("s6_d5_after", 32'(D5), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 99) < 2);
      w = ($urandom_range(0, 99) < 55);
      c = ($urandom_range(0, 99) < 6);
      applyStimulus(r, w, 4'($urandom_range(0, 11)), 8'($urandom), c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
